// File: rtl/decoder_seq.sv
// 3-to-8 one-hot decoder that holds each accepted code for HOLD cycles, then idles for GAP cycles.
// Optional sticky overrun detector compiled in with `define DECODER_SEQ_OVR_EN.
module decoder_seq #(
  parameter int unsigned HOLD = 4,  // 1..15
  parameter int unsigned GAP  = 1   // 0..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i,
  input  logic       en,
  input  logic       vld,
  output logic       rdy,
  output logic [7:0] o,
  output logic       busy,
  output logic       ovr
);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

  localparam logic [3:0] HOLD_M1 = 4'(HOLD - 1);
  localparam logic [3:0] GAP_M1  = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [7:0] o_nx;

  assign rdy = (state == S_IDLE) && en;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    o_nx     = o;
    unique case (state)
      S_IDLE: begin
        if (vld && rdy) begin
          state_nx = S_DRIVE;
          cnt_nx   = HOLD_M1;
          o_nx     = 8'b1 << i;
        end
      end
      S_DRIVE: begin
        if (!en) begin
          state_nx = S_IDLE;
          cnt_nx   = 4'd0;
          o_nx     = 8'h00;
        end else if (cnt == 4'd0) begin
          o_nx = 8'h00;
          if (GAP > 0) begin
            state_nx = S_GAP;
            cnt_nx   = GAP_M1;
          end else begin
            state_nx = S_IDLE;
          end
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      S_GAP: begin
        if (!en || cnt == 4'd0) begin
          state_nx = S_IDLE;
          cnt_nx   = 4'd0;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
        o_nx = 8'h00;
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = 4'd0;
        o_nx     = 8'h00;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  // busy is registered from the next state so it never glitches on state decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      o     <= 8'h00;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      o     <= o_nx;
      busy  <= (state_nx != S_IDLE);
    end
  end

`ifdef DECODER_SEQ_OVR_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     ovr <= 1'b0;
    else if (vld && en && busy)  ovr <= 1'b1;
  end
`else
  assign ovr = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_seq.sv
// Directed self-checking bench for decoder_seq: HOLD=4/GAP=1 instance plus a HOLD=4/GAP=0 instance
// for back-to-back acceptance.
module tb_decoder_seq;

  logic       clk = 1'b0;
  logic       rst, en, vld, vld2;
  logic [2:0] i, i2;
  logic       rdy, busy, ovr, rdy2, busy2, ovr2;
  logic [7:0] o, o2;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef DECODER_SEQ_OVR_EN
  localparam logic OVR_ON = 1'b1;
`else
  localparam logic OVR_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  decoder_seq #(.HOLD(4), .GAP(1)) dut (
    .clk(clk), .rst(rst), .i(i), .en(en), .vld(vld),
    .rdy(rdy), .o(o), .busy(busy), .ovr(ovr)
  );

  decoder_seq #(.HOLD(4), .GAP(0)) dut2 (
    .clk(clk), .rst(rst), .i(i2), .en(en), .vld(vld2),
    .rdy(rdy2), .o(o2), .busy(busy2), .ovr(ovr2)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept code, then follow the HOLD=4 / GAP=1 sequence back to IDLE.
  task automatic decode_run(input logic [2:0] code, input logic [7:0] exp_o);
    i   = code;
    vld = 1'b1;
    tick();
    vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      chk("drive_o", o, exp_o);
      chk("drive_busy", {7'd0, busy}, 8'd1);
      chk("drive_rdy", {7'd0, rdy}, 8'd0);
    end
    tick();
    chk("gap_o", o, 8'h00);
    chk("gap_busy", {7'd0, busy}, 8'd1);
    tick();
    chk("idle_o", o, 8'h00);
    chk("idle_busy", {7'd0, busy}, 8'd0);
    chk("idle_rdy", {7'd0, rdy}, 8'd1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; vld = 1'b1; i = 3'd5; vld2 = 1'b0; i2 = 3'd0;

    // Reset with a valid request pending
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_o", o, 8'h00);
      chk("rst_busy", {7'd0, busy}, 8'd0);
      chk("rst_ovr", {7'd0, ovr}, 8'd0);
      chk("rst_rdy", {7'd0, rdy}, 8'd1);
      tick();
    end
    rst = 1'b0;
    vld = 1'b0;

    // Basic decode, first acceptance right after reset release
    decode_run(3'd2, 8'h04);
    decode_run(3'd0, 8'h01);
    decode_run(3'd6, 8'h40);

    // Disable
    en = 1'b0; vld = 1'b1; i = 3'd7;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("dis_rdy", {7'd0, rdy}, 8'd0);
      chk("dis_o", o, 8'h00);
      chk("dis_busy", {7'd0, busy}, 8'd0);
    end
    vld = 1'b0;
    en  = 1'b1;
    tick();

    // Abort in the 2nd DRIVE cycle
    i = 3'd3; vld = 1'b1;
    tick();
    vld = 1'b0;
    chk("abt_o1", o, 8'h08);
    tick();
    chk("abt_o2", o, 8'h08);
    en = 1'b0; vld = 1'b1;
    tick();
    chk("abt_o", o, 8'h00);
    chk("abt_busy", {7'd0, busy}, 8'd0);
    chk("abt_rdy", {7'd0, rdy}, 8'd0);
    tick();
    chk("abt_hold_o", o, 8'h00);
    chk("abt_ovr", {7'd0, ovr}, 8'd0);
    en = 1'b1;
    #1;
    chk("abt_resume_rdy", {7'd0, rdy}, 8'd1);
    tick();
    vld = 1'b0;
    chk("abt_resume_o", o, 8'h08);
    repeat (5) tick();
    chk("abt_end_busy", {7'd0, busy}, 8'd0);

    // Async reset mid-DRIVE, with an overrun first
    i = 3'd1; vld = 1'b1;
    tick();
    chk("ar_o1", o, 8'h02);
    tick();
    vld = 1'b0;
    chk("ar_o2", o, 8'h02);
    chk("ar_ovr_set", {7'd0, ovr}, {7'd0, OVR_ON});
    #2 rst = 1'b1;
    #1;
    chk("ar_o", o, 8'h00);
    chk("ar_busy", {7'd0, busy}, 8'd0);
    chk("ar_ovr", {7'd0, ovr}, 8'd0);
    #1 rst = 1'b0;
    tick();
    chk("ar_post_o", o, 8'h00);
    chk("ar_post_rdy", {7'd0, rdy}, 8'd1);

    // Back-to-back on the GAP=0 instance: 5-cycle period, 4 drive + 1 idle
    i2 = 3'd5; vld2 = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      chk("b2b_o", o2, ((k % 5) == 4) ? 8'h00 : 8'h20);
      chk("b2b_rdy", {7'd0, rdy2}, ((k % 5) == 4) ? 8'd1 : 8'd0);
      chk("b2b_ovr", {7'd0, ovr2}, (k >= 1) ? {7'd0, OVR_ON} : 8'd0);
    end
    vld2 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
